// File: rtl/iic_target.sv
// I2C target exposing a byte-wide register file through a pointer-then-data protocol.
// SCL/SDA are synchronized and glitch-filtered, and the protocol FSM runs entirely on the filtered levels.
module iic_target #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         NUM_REGS = 8,
    parameter int         FILT_LEN = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        scl_i,
    output logic                        scl_o,
    output logic                        scl_t,
    input  logic                        sda_i,
    output logic                        sda_o,
    output logic                        sda_t,
    output logic [8*NUM_REGS-1:0]       regs,
    output logic                        reg_wr,
    output logic [$clog2(NUM_REGS)-1:0] reg_wr_addr,
    output logic                        busy
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(FILT_LEN + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [1:0]    w_pad;
    logic [1:0]    w_filt;
    logic          w_scl_f, w_sda_f, r_scl_d, r_sda_d;
    logic          w_rise, w_fall, w_start, w_stop, w_addr_hit;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift, r_tx;
    logic          r_rw, r_mst_ack, r_sda_t, r_busy, r_reg_wr;
    logic [AW-1:0] r_ptr, r_reg_wr_addr, w_ptr_inc;
    logic [7:0]    r_regs [NUM_REGS];
    logic [7:0]    w_cur_byte, w_next_byte;

    assign w_pad = {scl_i, sda_i};

    // Level changes only after FILT_LEN consecutive synchronized samples disagree with it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cond
        logic [1:0]    r_sync;
        logic [CW-1:0] r_cnt;
        logic          r_lvl;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync <= 2'b11;
                r_cnt  <= '0;
                r_lvl  <= 1'b1;
            end else begin
                r_sync <= {r_sync[0], w_pad[gi]};
                if (r_sync[1] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(FILT_LEN - 1)) begin
                    r_lvl <= r_sync[1];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
        assign w_filt[gi] = r_lvl;
    end

    assign w_scl_f     = w_filt[1];
    assign w_sda_f     = w_filt[0];
    assign w_rise      = w_scl_f & ~r_scl_d;
    assign w_fall      = ~w_scl_f & r_scl_d;
    assign w_start     = w_scl_f & r_scl_d & r_sda_d & ~w_sda_f;
    assign w_stop      = w_scl_f & r_scl_d & ~r_sda_d & w_sda_f;
    assign w_addr_hit  = (r_shift[7:1] == DEV_ADDR);
    assign w_ptr_inc   = r_ptr + AW'(1);
    assign w_cur_byte  = r_regs[r_ptr];
    assign w_next_byte = r_regs[w_ptr_inc];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = ADDR;
        end else if (w_stop) begin
            w_state_next = IDLE;
        end else if (w_fall) begin
            case (r_state)
                ADDR:      if (r_bit_cnt == 4'd8) w_state_next = w_addr_hit ? ADDR_ACK : IGNORE;
                ADDR_ACK:  w_state_next = r_rw ? RDATA : PTR;
                PTR:       if (r_bit_cnt == 4'd8) w_state_next = PTR_ACK;
                PTR_ACK:   w_state_next = WDATA;
                WDATA:     if (r_bit_cnt == 4'd8) w_state_next = WDATA_ACK;
                WDATA_ACK: w_state_next = WDATA;
                RDATA:     if (r_bit_cnt == 4'd8) w_state_next = RD_ACK;
                RD_ACK:    w_state_next = r_mst_ack ? RDATA : IGNORE;
                default:   w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_d       <= 1'b1;
            r_sda_d       <= 1'b1;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_tx          <= '0;
            r_rw          <= 1'b0;
            r_mst_ack     <= 1'b0;
            r_sda_t       <= 1'b1;
            r_busy        <= 1'b0;
            r_reg_wr      <= 1'b0;
            r_reg_wr_addr <= '0;
            r_ptr         <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_scl_d  <= w_scl_f;
            r_sda_d  <= w_sda_f;
            r_reg_wr <= 1'b0;
            // START/STOP take priority over any bit event in the same cycle.
            if (w_start) begin
                r_bit_cnt <= '0;
                r_sda_t   <= 1'b1;
                r_busy    <= 1'b0;
            end else if (w_stop) begin
                r_sda_t <= 1'b1;
                r_busy  <= 1'b0;
            end else if (w_rise) begin
                if (r_state == ADDR || r_state == PTR || r_state == WDATA) begin
                    r_shift   <= {r_shift[6:0], w_sda_f};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                if (r_state == RD_ACK) r_mst_ack <= ~w_sda_f;
            end else if (w_fall) begin
                case (r_state)
                    ADDR: if (r_bit_cnt == 4'd8) begin
                        r_bit_cnt <= '0;
                        r_rw      <= r_shift[0];
                        if (w_addr_hit) begin
                            r_sda_t <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                    ADDR_ACK: if (r_rw) begin
                        r_tx      <= w_cur_byte;
                        r_sda_t   <= w_cur_byte[7];
                        r_bit_cnt <= 4'd1;
                    end else begin
                        r_sda_t <= 1'b1;
                    end
                    PTR: if (r_bit_cnt == 4'd8) begin
                        r_ptr     <= r_shift[AW-1:0];
                        r_sda_t   <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                    WDATA: if (r_bit_cnt == 4'd8) begin
                        r_regs[r_ptr] <= r_shift;
                        r_reg_wr      <= 1'b1;
                        r_reg_wr_addr <= r_ptr;
                        r_ptr         <= w_ptr_inc;
                        r_sda_t       <= 1'b0;
                        r_bit_cnt     <= '0;
                    end
                    // r_bit_cnt counts bits already driven; bit 7 went out on entry.
                    RDATA: if (r_bit_cnt == 4'd8) begin
                        r_sda_t <= 1'b1;
                    end else begin
                        r_sda_t   <= r_tx[6];
                        r_tx      <= {r_tx[6:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                    RD_ACK: if (r_mst_ack) begin
                        r_ptr     <= w_ptr_inc;
                        r_tx      <= w_next_byte;
                        r_sda_t   <= w_next_byte[7];
                        r_bit_cnt <= 4'd1;
                    end else begin
                        r_sda_t <= 1'b1;
                    end
                    default: r_sda_t <= 1'b1;
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs[8*gi +: 8] = r_regs[gi];
    end

    assign scl_o       = 1'b0;
    assign scl_t       = 1'b1;
    assign sda_o       = 1'b0;
    assign sda_t       = r_sda_t;
    assign reg_wr      = r_reg_wr;
    assign reg_wr_addr = r_reg_wr_addr;
    assign busy        = r_busy;
endmodule

// File: tb/tb_iic_target.sv
// Bench for iic_target: acts as the I2C controller on an open-drain bus model and checks
// responses against a transaction-level register/pointer model.
module tb_iic_target;
    localparam int N = 8;
    localparam int Q = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           scl = 1'b1;
    logic           sda_drv = 1'b1;
    logic           scl_o, scl_t, sda_o, sda_t, reg_wr, busy;
    logic [8*N-1:0] regs;
    logic [2:0]     reg_wr_addr;
    wire            bus_sda = sda_drv & (sda_t | sda_o);

    int             n_checks = 0;
    int             n_err = 0;
    logic [7:0]     m_regs [N];
    int             m_ptr = 0;
    int             exp_wr_q[$];
    int             wr_q[$];
    logic [7:0]     tx_q[$];

    always #5 clk = ~clk;

    iic_target #(.DEV_ADDR(7'h50), .NUM_REGS(N), .FILT_LEN(3)) dut (
        .clk(clk), .reset(reset),
        .scl_i(scl), .scl_o(scl_o), .scl_t(scl_t),
        .sda_i(bus_sda), .sda_o(sda_o), .sda_t(sda_t),
        .regs(regs), .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .busy(busy)
    );

    always @(negedge clk) if (reg_wr) wr_q.push_back(int'(reg_wr_addr));

    initial begin
        #950us;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < N; k++)
            check($sformatf("%s_reg%0d", tag, k), 32'(regs[8*k +: 8]), 32'(m_regs[k]));
    endtask

    task automatic xfer_bit(input logic tx, input bit gl, output logic rx);
        sda_drv = tx;
        wclk(Q);
        scl = 1'b1;
        wclk(Q);
        if (gl) begin
            scl = 1'b0;
            wclk(1);
            scl = 1'b1;
        end
        wclk(Q);
        rx = bus_sda;
        scl = 1'b0;
        wclk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gl, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], gl && (i == 3), r);
        xfer_bit(1'b1, 1'b0, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, 1'b0, r);
            b[i] = r;
        end
        xfer_bit(~mack, 1'b0, r);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b0; wclk(2*Q);
        scl = 1'b0;     wclk(Q);
    endtask

    task automatic i2c_rstart();
        sda_drv = 1'b1; wclk(Q);
        scl = 1'b1;     wclk(2*Q);
        sda_drv = 1'b0; wclk(2*Q);
        scl = 1'b0;     wclk(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wclk(Q);
        scl = 1'b1;     wclk(2*Q);
        sda_drv = 1'b1; wclk(2*Q);
    endtask

    // Write transaction: address, pointer byte, then every byte in tx_q.
    task automatic wr_txn(input logic [6:0] a, input logic [7:0] p, input bit gl);
        logic ack;
        bit   hit;
        hit = (a == 7'h50);
        wr_q.delete();
        exp_wr_q.delete();
        i2c_start();
        send_byte({a, 1'b0}, 1'b0, ack);
        check("wr_addr_ack", 32'(ack), 32'(hit));
        send_byte(p, 1'b0, ack);
        check("wr_ptr_ack", 32'(ack), 32'(hit));
        if (hit) m_ptr = p % N;
        foreach (tx_q[i]) begin
            send_byte(tx_q[i], gl, ack);
            check("wr_data_ack", 32'(ack), 32'(hit));
            if (hit) begin
                m_regs[m_ptr] = tx_q[i];
                exp_wr_q.push_back(m_ptr);
                m_ptr = (m_ptr + 1) % N;
            end
        end
        check("wr_busy_before_stop", 32'(busy), 32'(hit));
        i2c_stop();
        wclk(Q);
        check("wr_busy_after_stop", 32'(busy), 32'(0));
        check("wr_pulse_count", 32'(wr_q.size()), 32'(exp_wr_q.size()));
        foreach (exp_wr_q[i])
            if (i < wr_q.size()) check("wr_pulse_addr", 32'(wr_q[i]), 32'(exp_wr_q[i]));
        check_regs("wr");
        $display("write a=%02h p=%02h n=%0d glitch=%0d", a, p, tx_q.size(), gl);
    endtask

    // Pointer-only write, repeated START, read n bytes (ACK all but the last).
    task automatic ptr_read(input logic [7:0] p, input int n);
        logic       ack;
        logic [7:0] b;
        i2c_start();
        send_byte(8'hA0, 1'b0, ack);
        check("rd_addr_w_ack", 32'(ack), 32'(1));
        send_byte(p, 1'b0, ack);
        check("rd_ptr_ack", 32'(ack), 32'(1));
        m_ptr = p % N;
        i2c_rstart();
        send_byte(8'hA1, 1'b0, ack);
        check("rd_addr_r_ack", 32'(ack), 32'(1));
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, b);
            check($sformatf("rd_data%0d", i), 32'(b), 32'(m_regs[m_ptr]));
            if (i < n - 1) m_ptr = (m_ptr + 1) % N;
        end
        check("rd_sda_released_after_nack", 32'(sda_t), 32'(1));
        check("rd_busy_before_stop", 32'(busy), 32'(1));
        i2c_stop();
        wclk(Q);
        check("rd_busy_after_stop", 32'(busy), 32'(0));
        $display("read p=%02h n=%0d", p, n);
    endtask

    initial begin
        logic       ack, r;
        logic [6:0] a;
        logic [7:0] p;
        int         n;

        for (int k = 0; k < N; k++) m_regs[k] = 8'h00;
        wclk(3);
        check("rst_sda_t", 32'(sda_t), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_reg_wr", 32'(reg_wr), 32'(0));
        check("rst_reg_wr_addr", 32'(reg_wr_addr), 32'(0));
        check("rst_scl_t", 32'(scl_t), 32'(1));
        check("rst_scl_o_sda_o", 32'({scl_o, sda_o}), 32'(0));
        check_regs("rst");
        reset = 1'b0;
        wclk(10);

        tx_q = '{8'h11, 8'h22};
        wr_txn(7'h50, 8'h02, 1'b0);
        ptr_read(8'h03, 2);

        tx_q = '{8'hAA, 8'hBB};
        wr_txn(7'h50, 8'h07, 1'b0);
        ptr_read(8'h0F, 1);

        tx_q = '{8'h5C, 8'hC5};
        wr_txn(7'h51, 8'h01, 1'b0);

        tx_q = '{8'hB6, 8'h49};
        wr_txn(7'h50, 8'h04, 1'b1);
        ptr_read(8'h04, 2);

        for (int it = 0; it < 6; it++) begin
            p = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 2) < 2) begin
                a = ($urandom_range(0, 4) == 0) ? 7'h51 : 7'h50;
                tx_q.delete();
                for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom_range(0, 255)));
                wr_txn(a, p, 1'b0);
            end else begin
                ptr_read(p, n);
            end
        end

        // Asynchronous reset while the target drives a 0 data bit.
        tx_q = '{8'h0F};
        wr_txn(7'h50, 8'h05, 1'b0);
        i2c_start();
        send_byte(8'hA0, 1'b0, ack);
        send_byte(8'h05, 1'b0, ack);
        i2c_rstart();
        send_byte(8'hA1, 1'b0, ack);
        check("mid_rd_addr_ack", 32'(ack), 32'(1));
        sda_drv = 1'b1;
        wclk(Q);
        scl = 1'b1;
        wclk(Q);
        check("mid_rd_sda_driven_low", 32'(sda_t), 32'(0));
        #2 reset = 1'b1;
        #1;
        check("mid_rd_sda_released_async", 32'(sda_t), 32'(1));
        check("mid_rd_busy_cleared", 32'(busy), 32'(0));
        for (int k = 0; k < N; k++) m_regs[k] = 8'h00;
        m_ptr = 0;
        check_regs("mid_rd_rst");
        $display("reset asserted during read");
        wclk(3);
        reset = 1'b0;
        wclk(20);

        tx_q = '{8'h5A};
        wr_txn(7'h50, 8'h01, 1'b0);
        ptr_read(8'h01, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
